gpu_raster_unit: RTL and testbench

Parametrised raster back-end for the mapache64 GPU. It generates video timing and the prefetch schedule. It composites up to `NUM_LAYERS` layer pixels by fixed priority over a programmable backdrop, registers the RGB and sync outputs, and raises maskable vblank and raster-line interrupts through a small CPU register file. It sits between the layer engines (text, foreground, background, and any future layers) and the video DAC pins.

---
 rtl/gpu_raster_unit.sv | 150 +++++++++++++++
 tb/tb_gpu_raster_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_raster_unit.sv
// Raster back-end: video timing, line-prefetch schedule, fixed-priority layer
// compositing over a backdrop, registered RGB/sync and a small CPU IRQ register file.
module gpu_raster_unit #(
  parameter int NUM_LAYERS   = 4,
  parameter int COLOR_BITS   = 2,
  parameter int H_TOTAL      = 400,
  parameter int H_VISIBLE    = 320,
  parameter int H_SYNC_START = 328,
  parameter int H_SYNC_LEN   = 48,
  parameter int V_TOTAL      = 525,
  parameter int V_VISIBLE    = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_LEN   = 2,
  parameter int X_OFFSET     = 31,
  parameter int FRAME_W      = 256,
  parameter int FRAME_H      = 240
) (
  input  logic                                   gpu_clk,
  input  logic                                   rst,
  input  logic [NUM_LAYERS*3*COLOR_BITS-1:0]     layer_rgb_i,
  input  logic [NUM_LAYERS-1:0]                  layer_valid_i,
  output logic [7:0]                             next_x_o,
  output logic [7:0]                             next_y_o,
  output logic                                   prefetch_start_o,
  output logic [7:0]                             prefetch_y_o,
  output logic [COLOR_BITS-1:0]                  r_o,
  output logic [COLOR_BITS-1:0]                  g_o,
  output logic [COLOR_BITS-1:0]                  b_o,
  output logic                                   hsync_o,
  output logic                                   vsync_o,
  input  logic [2:0]                             reg_addr_i,
  input  logic                                   reg_wen_i,
  input  logic [7:0]                             reg_wdata_i,
  output logic [7:0]                             reg_rdata_o,
  output logic                                   irq_o
);

  localparam int PW = 3 * COLOR_BITS;

  logic [9:0]            r_hcnt, r_vcnt;
  logic [PW-1:0]         r_rgb;
  logic                  r_hsync, r_vsync, r_irq;
  logic                  r_vbl_pend, r_line_pend;
  logic [1:0]            r_irq_en;
  logic [7:0]            r_line_cmp;
  logic [NUM_LAYERS-1:0] r_layer_en;
  logic [7:0]            r_backdrop;

  logic [8:0]    w_x9;
  logic [9:0]    w_ny1;
  logic          w_draw, w_vblank, w_last_line, w_h0;
  logic          w_hs_d, w_vs_d;
  logic          w_vbl_set, w_line_set, w_wr_stat;
  logic [PW-1:0] w_bd, w_pix;

  // Negative x wraps to >= 256 in 9 bits and so falls outside the frame.
  assign w_x9     = 9'(r_hcnt - 10'(X_OFFSET));
  assign w_draw   = (r_hcnt < 10'(H_VISIBLE)) && (r_vcnt < 10'(V_VISIBLE)) &&
                    ({1'b0, w_x9} < 10'(FRAME_W)) && ((r_vcnt >> 1) < 10'(FRAME_H));
  assign w_vblank = r_vcnt >= 10'(V_VISIBLE);
  assign w_h0     = r_hcnt == 10'd0;

  assign next_x_o = w_x9[7:0];
  assign next_y_o = r_vcnt[8:1];

  assign w_last_line      = r_vcnt == 10'(V_TOTAL-1);
  assign w_ny1            = (r_vcnt >> 1) + 10'd1;
  assign prefetch_start_o = !rst && w_h0 &&
                            (w_last_line || (!r_vcnt[0] && (w_ny1 < 10'(FRAME_H))));
  assign prefetch_y_o     = w_last_line ? 8'd0 : w_ny1[7:0];

  assign w_hs_d = !((r_hcnt >= 10'(H_SYNC_START)) && (r_hcnt < 10'(H_SYNC_START+H_SYNC_LEN)));
  assign w_vs_d = !((r_vcnt >= 10'(V_SYNC_START)) && (r_vcnt < 10'(V_SYNC_START+V_SYNC_LEN)));

  // Backdrop holds {r,g,b} in its low bits; zero-padded when wider than 8.
  assign w_bd = PW'(r_backdrop);

  always_comb begin
    w_pix = w_bd;
    for (int n = NUM_LAYERS-1; n >= 0; n--)
      if (layer_valid_i[n] && r_layer_en[n]) w_pix = layer_rgb_i[n*PW +: PW];
    if (!w_draw) w_pix = '0;
  end

  // LINE_CMP values at or past half a frame never match, even if 2*cmp fits.
  assign w_vbl_set  = w_h0 && (r_vcnt == 10'(V_VISIBLE));
  assign w_line_set = w_h0 && !r_vcnt[9] && (r_vcnt[8:0] == {r_line_cmp, 1'b0}) &&
                      (10'(r_line_cmp) < 10'(V_TOTAL/2));
  assign w_wr_stat  = reg_wen_i && (reg_addr_i == 3'd0);

  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      r_hcnt      <= '0;
      r_vcnt      <= '0;
      r_rgb       <= '0;
      r_hsync     <= 1'b1;
      r_vsync     <= 1'b1;
      r_irq       <= 1'b0;
      r_vbl_pend  <= 1'b0;
      r_line_pend <= 1'b0;
      r_irq_en    <= '0;
      r_line_cmp  <= 8'hFF;
      r_layer_en  <= '1;
      r_backdrop  <= '0;
    end else begin
      if (r_hcnt == 10'(H_TOTAL-1)) begin
        r_hcnt <= '0;
        r_vcnt <= w_last_line ? 10'd0 : r_vcnt + 10'd1;
      end else begin
        r_hcnt <= r_hcnt + 10'd1;
      end
      r_rgb   <= w_pix;
      r_hsync <= w_hs_d;
      r_vsync <= w_vs_d;
      // Set beats a coincident write-1-clear.
      r_vbl_pend  <= w_vbl_set  || (r_vbl_pend  && !(w_wr_stat && reg_wdata_i[1]));
      r_line_pend <= w_line_set || (r_line_pend && !(w_wr_stat && reg_wdata_i[2]));
      r_irq       <= |({r_line_pend, r_vbl_pend} & r_irq_en);
      if (reg_wen_i) begin
        case (reg_addr_i)
          3'd1:    r_irq_en   <= reg_wdata_i[2:1];
          3'd2:    r_line_cmp <= reg_wdata_i;
          3'd3:    r_layer_en <= reg_wdata_i[NUM_LAYERS-1:0];
          3'd4:    r_backdrop <= reg_wdata_i;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    reg_rdata_o = '0;
    case (reg_addr_i)
      3'd0:    reg_rdata_o = {5'b0, r_line_pend, r_vbl_pend, w_vblank};
      3'd1:    reg_rdata_o = {5'b0, r_irq_en, 1'b0};
      3'd2:    reg_rdata_o = r_line_cmp;
      3'd3:    reg_rdata_o = 8'(r_layer_en);
      3'd4:    reg_rdata_o = r_backdrop;
      default: reg_rdata_o = '0;
    endcase
  end

  assign r_o     = r_rgb[PW-1 -: COLOR_BITS];
  assign g_o     = r_rgb[2*COLOR_BITS-1 -: COLOR_BITS];
  assign b_o     = r_rgb[COLOR_BITS-1:0];
  assign hsync_o = r_hsync;
  assign vsync_o = r_vsync;
  assign irq_o   = r_irq;

endmodule

// File: tb/tb_gpu_raster_unit.sv
// Directed bench for gpu_raster_unit on a shrunken 40x20 raster (800-clock frame)
// so whole-frame timing, prefetch, compositing and IRQ behaviour fit a short run.
module tb_gpu_raster_unit;
  localparam int NL = 4, CB = 2;
  localparam int HT = 40, HV = 32, HSS = 33, HSL = 4;
  localparam int VT = 20, VV = 16, VSS = 17, VSL = 2;
  localparam int XO = 3, FW = 24, FH = 6;

  logic              gpu_clk = 1'b0;
  logic              rst = 1'b1;
  logic [NL*3*CB-1:0] layer_rgb = '0;
  logic [NL-1:0]     layer_valid = '0;
  logic [7:0]        next_x, next_y, prefetch_y, reg_rdata;
  logic              prefetch_start, hsync, vsync, irq;
  logic [CB-1:0]     r_o, g_o, b_o;
  logic [2:0]        reg_addr = '0;
  logic              reg_wen = 1'b0;
  logic [7:0]        reg_wdata = '0;
  logic [5:0]        rgb;

  assign rgb = {r_o, g_o, b_o};

  gpu_raster_unit #(
    .NUM_LAYERS(NL), .COLOR_BITS(CB), .H_TOTAL(HT), .H_VISIBLE(HV),
    .H_SYNC_START(HSS), .H_SYNC_LEN(HSL), .V_TOTAL(VT), .V_VISIBLE(VV),
    .V_SYNC_START(VSS), .V_SYNC_LEN(VSL), .X_OFFSET(XO), .FRAME_W(FW), .FRAME_H(FH)
  ) dut (
    .gpu_clk(gpu_clk), .rst(rst), .layer_rgb_i(layer_rgb), .layer_valid_i(layer_valid),
    .next_x_o(next_x), .next_y_o(next_y), .prefetch_start_o(prefetch_start),
    .prefetch_y_o(prefetch_y), .r_o(r_o), .g_o(g_o), .b_o(b_o),
    .hsync_o(hsync), .vsync_o(vsync), .reg_addr_i(reg_addr), .reg_wen_i(reg_wen),
    .reg_wdata_i(reg_wdata), .reg_rdata_o(reg_rdata), .irq_o(irq)
  );

  always #5 gpu_clk = ~gpu_clk;

  int nvec = 0, nerr = 0, t = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // t counts clocks since the counters were last reset to (0,0).
  task automatic tick();
    @(posedge gpu_clk);
    #1;
    t = rst ? 0 : t + 1;
  endtask

  task automatic goto(input int h, input int v);
    int n = 0;
    while (!((t % HT) == h && ((t / HT) % VT) == v) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) begin
      nerr++;
      $display("FAIL goto(%0d,%0d): not reached within 2000 cycles", h, v);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    reg_addr = a; reg_wdata = d; reg_wen = 1'b1;
    tick();
    reg_wen = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [7:0] exp);
    reg_addr = a;
    #1;
    chk(tag, 32'(reg_rdata), 32'(exp));
  endtask

  initial begin
    logic [7:0] pf_y[$];
    logic [7:0] pf_exp[6];
    int vfall[$];
    int hs_low, hs_first, vs_low;
    logic vs_prev;

    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_hsync", 32'(hsync), 1);
    chk("rst_vsync", 32'(vsync), 1);
    chk("rst_rgb", 32'(rgb), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("x_at_h0", 32'(next_x), 'hFD);
    chk("pf_v0", 32'({prefetch_start, prefetch_y}), 'h101);
    rd("rst_layer_en", 3'd3, 8'h0F);
    rd("rst_line_cmp", 3'd2, 8'hFF);
    rd("rst_status", 3'd0, 8'h00);

    // Two frames of free-running timing.
    hs_low = 0; hs_first = -1; vs_low = 0; vs_prev = 1'b1;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      if (i < HT * VT && prefetch_start) pf_y.push_back(prefetch_y);
      if (i < HT && !hsync) begin
        hs_low++;
        if (hs_first < 0) hs_first = i;
      end
      if (i < HT * VT && !vsync) vs_low++;
      if (vs_prev && !vsync) vfall.push_back(i);
      vs_prev = vsync;
      tick();
    end
    chk("hsync_low_len", 32'(hs_low), 4);
    chk("hsync_first", 32'(hs_first), 34);
    chk("vsync_low_len", 32'(vs_low), 80);
    chk("vsync_falls", 32'(vfall.size()), 2);
    if (vfall.size() == 2) begin
      chk("vsync_first", 32'(vfall[0]), 681);
      chk("frame_len", 32'(vfall[1] - vfall[0]), 800);
    end
    pf_exp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0};
    chk("pf_count", 32'(pf_y.size()), 6);
    for (int k = 0; k < 6 && k < pf_y.size(); k++) chk($sformatf("pf_y%0d", k), 32'(pf_y[k]), 32'(pf_exp[k]));
    rd("status_idle", 3'd0, 8'h02);

    // Compositing: layer0=11_00_01, layer1=00_11_11, layer2=01_10_11, layer3=11_11_11.
    goto(10, 1);
    chk("next_x", 32'(next_x), 7);
    chk("next_y", 32'(next_y), 0);
    layer_rgb = {6'h3F, 6'h1B, 6'h0F, 6'h31};
    layer_valid = 4'b0101;
    tick();
    chk("prio_l0", 32'(rgb), 'h31);
    wr(3'd3, 8'h0E);
    tick();
    chk("en_mask_l2", 32'(rgb), 'h1B);
    layer_valid = 4'b0010;
    tick();
    chk("en_l1", 32'(rgb), 'h0F);
    wr(3'd4, 8'h2A);
    layer_valid = 4'b0000;
    tick();
    chk("backdrop", 32'(rgb), 'h2A);
    rd("backdrop_rd", 3'd4, 8'h2A);
    goto(26, 2); tick();
    chk("x_last", 32'(rgb), 'h2A);
    tick();
    chk("x_eq_w", 32'(rgb), 0);
    goto(2, 3); tick();
    chk("x_neg", 32'(rgb), 0);
    tick();
    chk("x_zero", 32'(rgb), 'h2A);
    goto(10, 11); tick();
    chk("y_last", 32'(rgb), 'h2A);
    goto(10, 12); tick();
    chk("y_eq_h", 32'(rgb), 0);
    wr(3'd5, 8'hFF);
    rd("reg5", 3'd5, 8'h00);

    // VBL interrupt rise/fall and set-vs-clear priority.
    wr(3'd0, 8'h06);
    wr(3'd1, 8'h02);
    rd("irq_en_rd", 3'd1, 8'h02);
    goto(0, 16);
    chk("irq_pre", 32'(irq), 0);
    tick();
    rd("vbl_pend", 3'd0, 8'h03);
    chk("irq_lag1", 32'(irq), 0);
    tick();
    chk("irq_rise", 32'(irq), 1);
    wr(3'd0, 8'h02);
    rd("vbl_clr", 3'd0, 8'h01);
    chk("irq_hold", 32'(irq), 1);
    tick();
    chk("irq_fall", 32'(irq), 0);
    goto(0, 16);
    reg_addr = 3'd0; reg_wdata = 8'h02; reg_wen = 1'b1;
    tick();
    reg_wen = 1'b0;
    rd("set_wins", 3'd0, 8'h03);

    // Line-compare interrupt.
    wr(3'd1, 8'h04);
    wr(3'd2, 8'd5);
    wr(3'd0, 8'h06);
    goto(39, 9);
    rd("line_pre", 3'd0, 8'h00);
    tick(); tick();
    rd("line_set", 3'd0, 8'h04);
    tick();
    chk("line_irq", 32'(irq), 1);
    wr(3'd0, 8'h04);
    goto(39, 9);
    rd("line_once", 3'd0, 8'h02);
    wr(3'd2, 8'hFF);
    wr(3'd0, 8'h06);
    goto(38, 9);
    rd("cmp_ff", 3'd0, 8'h02);
    chk("cmp_ff_irq", 32'(irq), 0);

    // Mid-line reset while drawing with an interrupt pending.
    wr(3'd2, 8'd5);
    goto(15, 11);
    chk("pre_rst_irq", 32'(irq), 1);
    chk("pre_rst_rgb", 32'(rgb), 'h2A);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_hsync", 32'(hsync), 1);
    chk("mrst_vsync", 32'(vsync), 1);
    chk("mrst_irq", 32'(irq), 0);
    chk("mrst_rgb", 32'(rgb), 0);
    chk("mrst_xy", 32'({next_x, next_y}), 'hFD00);
    rd("mrst_status", 3'd0, 8'h00);
    rd("mrst_layer_en", 3'd3, 8'h0F);
    rd("mrst_irq_en", 3'd1, 8'h00);
    rd("mrst_backdrop", 3'd4, 8'h00);

    // Reset held on a prefetch cycle suppresses the pulse.
    goto(0, 4);
    chk("pf_v4", 32'({prefetch_start, prefetch_y}), 'h103);
    rst = 1'b1;
    #1;
    chk("pf_in_rst", 32'(prefetch_start), 0);
    tick();
    rst = 1'b0;
    #1;
    chk("pf_after_rst", 32'({prefetch_start, prefetch_y}), 'h101);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
